// File: rtl/video_sync_cleaner_if.sv
// Raw/clean video bundle for the sync cleaner.
// master drives raw video and sees cleaned output; slave is the cleaner.
interface video_sync_cleaner_if;
  logic        iCE;
  logic [23:0] iRGB;
  logic        iHS;
  logic        iVS;
  logic        iHBLANK;
  logic        iVBLANK;
  logic [23:0] oRGB;
  logic        oHS;
  logic        oVS;
  logic        oDE;
  logic        oCE;

  modport master (
    output iCE, iRGB, iHS, iVS,
    output iHBLANK, iVBLANK,
    input  oRGB, oHS, oVS, oDE, oCE
  );

  modport slave (
    input  iCE, iRGB, iHS, iVS,
    input  iHBLANK, iVBLANK,
    output oRGB, oHS, oVS, oDE, oCE
  );
endinterface

// File: rtl/video_sync_cleaner.sv
// Sync polarity normaliser, VS-to-HS realigner and DE/blank generator.
// Feeds the scanlines stage with active-high syncs and black borders.
module video_sync_cleaner #(
  parameter int unsigned H_CNT_W     = 12,
  parameter int unsigned V_CNT_W     = 10,
  parameter bit          BLANK_BLACK = 1'b1
) (
  input logic                 iPCLK,
  input logic                 iRST,
  video_sync_cleaner_if.slave vid
);

  logic               hsPrev;
  logic               polH;
  logic [H_CNT_W-1:0] hCntHi;
  logic [H_CNT_W-1:0] hCntLo;

  logic               hsnPrev;
  logic               vsPrev;
  logic               polV;
  logic [V_CNT_W-1:0] vCntHi;
  logic [V_CNT_W-1:0] vCntLo;

  logic               hblPrev;
  logic               vbl;

  logic               hsRise;
  logic               hsN;
  logic               hsnRise;
  logic               vsRise;
  logic               vsN;
  logic               hblRise;
  logic               vblNx;
  logic               deNx;
  logic [23:0]        rgbNx;
  logic [H_CNT_W-1:0] hHiInc;
  logic [H_CNT_W-1:0] hLoInc;
  logic [V_CNT_W-1:0] vHiInc;
  logic [V_CNT_W-1:0] vLoInc;

  // Syncs are normalised with the polarity held before this sample.
  always_comb begin
    hsRise  = vid.iHS & ~hsPrev;
    hsN     = vid.iHS ^ polH;
    hsnRise = hsN & ~hsnPrev;
    vsRise  = vid.iVS & ~vsPrev;
    vsN     = vid.iVS ^ polV;
    hblRise = vid.iHBLANK & ~hblPrev;
    vblNx   = hblRise ? vid.iVBLANK : vbl;
    deNx    = ~(vid.iHBLANK | vblNx);
    rgbNx   = (BLANK_BLACK && !deNx) ? 24'h0
                                     : vid.iRGB;
  end

  always_comb begin
    hHiInc = (&hCntHi) ? hCntHi
                       : hCntHi + H_CNT_W'(1);
    hLoInc = (&hCntLo) ? hCntLo
                       : hCntLo + H_CNT_W'(1);
    vHiInc = (&vCntHi) ? vCntHi
                       : vCntHi + V_CNT_W'(1);
    vLoInc = (&vCntLo) ? vCntLo
                       : vCntLo + V_CNT_W'(1);
  end

  // HS polarity: majority of high vs low time, decided at each raw rise.
  always_ff @(posedge iPCLK) begin
    if (iRST) begin
      hsPrev <= 1'b0;
      polH   <= 1'b0;
      hCntHi <= '0;
      hCntLo <= '0;
    end else if (vid.iCE) begin
      hsPrev <= vid.iHS;
      if (hsRise) begin
        polH   <= (hCntHi > hCntLo);
        hCntHi <= H_CNT_W'(1);
        hCntLo <= '0;
      end else if (vid.iHS) begin
        hCntHi <= hHiInc;
      end else begin
        hCntLo <= hLoInc;
      end
    end
  end

  // VS polarity counted in lines, one step per clean HS leading edge.
  always_ff @(posedge iPCLK) begin
    if (iRST) begin
      hsnPrev <= 1'b0;
      vsPrev  <= 1'b0;
      polV    <= 1'b0;
      vCntHi  <= '0;
      vCntLo  <= '0;
    end else if (vid.iCE) begin
      hsnPrev <= hsN;
      if (hsnRise) begin
        vsPrev <= vid.iVS;
        if (vsRise) begin
          polV   <= (vCntHi > vCntLo);
          vCntHi <= V_CNT_W'(1);
          vCntLo <= '0;
        end else if (vid.iVS) begin
          vCntHi <= vHiInc;
        end else begin
          vCntLo <= vLoInc;
        end
      end
    end
  end

  always_ff @(posedge iPCLK) begin
    if (iRST) begin
      hblPrev  <= 1'b0;
      vbl      <= 1'b0;
      vid.oHS  <= 1'b0;
      vid.oVS  <= 1'b0;
      vid.oDE  <= 1'b0;
      vid.oRGB <= '0;
    end else if (vid.iCE) begin
      hblPrev  <= vid.iHBLANK;
      vbl      <= vblNx;
      vid.oHS  <= hsN;
      vid.oDE  <= deNx;
      vid.oRGB <= rgbNx;
      if (hsnRise) begin
        vid.oVS <= vsN;
      end
    end
  end

  always_ff @(posedge iPCLK) begin
    if (iRST) begin
      vid.oCE <= 1'b0;
    end else begin
      vid.oCE <= vid.iCE;
    end
  end

endmodule

// File: tb/tb_video_sync_cleaner.sv
// Directed bench for video_sync_cleaner with a queued scoreboard.
// Two instances: blanking to black, and RGB pass-through.
module tb_video_sync_cleaner;

  localparam bit [5:0] M_HS   = 6'd1;
  localparam bit [5:0] M_VS   = 6'd2;
  localparam bit [5:0] M_DE   = 6'd4;
  localparam bit [5:0] M_RGB  = 6'd8;
  localparam bit [5:0] M_RGBB = 6'd16;
  localparam bit [5:0] M_CE   = 6'd32;
  localparam bit [5:0] M_ALL  = 6'd63;

  typedef struct {
    bit [5:0]    m;
    bit          hs;
    bit          vs;
    bit          de;
    bit          ce;
    logic [23:0] rgb;
    logic [23:0] rgbB;
    string       tag;
  } exp_t;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  exp_t sb[$];
  exp_t e;

  video_sync_cleaner_if vidA ();
  video_sync_cleaner_if vidB ();

  assign vidB.iCE     = vidA.iCE;
  assign vidB.iRGB    = vidA.iRGB;
  assign vidB.iHS     = vidA.iHS;
  assign vidB.iVS     = vidA.iVS;
  assign vidB.iHBLANK = vidA.iHBLANK;
  assign vidB.iVBLANK = vidA.iVBLANK;

  video_sync_cleaner dutA (
    .iPCLK (clk),
    .iRST  (rst),
    .vid   (vidA)
  );

  video_sync_cleaner #(.BLANK_BLACK(1'b0)) dutB (
    .iPCLK (clk),
    .iRST  (rst),
    .vid   (vidB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void cmp(string tag, string nm,
                              logic [23:0] act,
                              logic [23:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      if (mismatched <= 40)
        $display("FAIL %s/%s: got %h want %h",
                 tag, nm, act, exp);
    end
  endfunction

  // Monitor: one expected entry per clock, checked 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.m[0]) cmp(e.tag, "oHS", 24'(vidA.oHS), 24'(e.hs));
      if (e.m[1]) cmp(e.tag, "oVS", 24'(vidA.oVS), 24'(e.vs));
      if (e.m[2]) cmp(e.tag, "oDE", 24'(vidA.oDE), 24'(e.de));
      if (e.m[3]) cmp(e.tag, "oRGB", vidA.oRGB, e.rgb);
      if (e.m[4]) cmp(e.tag, "oRGB_pass", vidB.oRGB, e.rgbB);
      if (e.m[5]) cmp(e.tag, "oCE", 24'(vidA.oCE), 24'(e.ce));
    end
  end

  task automatic step(input bit r, input bit ce,
                      input bit hs, input bit vs,
                      input bit hb, input bit vb,
                      input logic [23:0] rgb,
                      input bit [5:0] m,
                      input bit ehs, input bit evs,
                      input bit ede,
                      input logic [23:0] ergb,
                      input logic [23:0] ergbB,
                      input bit ece, input string tag);
    exp_t x;
    @(negedge clk);
    rst          = r;
    vidA.iCE     = ce;
    vidA.iHS     = hs;
    vidA.iVS     = vs;
    vidA.iHBLANK = hb;
    vidA.iVBLANK = vb;
    vidA.iRGB    = rgb;
    x.m    = m;
    x.hs   = ehs;
    x.vs   = evs;
    x.de   = ede;
    x.rgb  = ergb;
    x.rgbB = ergbB;
    x.ce   = ece;
    x.tag  = tag;
    sb.push_back(x);
  endtask

  task automatic do_reset(input string tag);
    for (int i = 0; i < 2; i++)
      step(1, 1, 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 24'($urandom),
           M_ALL, 0, 0, 0, 24'h0, 24'h0, 0, tag);
  endtask

  function automatic bit vsLine(int l);
    if (l < 2)  return 1'b0;
    if (l < 12) return 1'b1;
    if (l < 14) return 1'b0;
    if (l < 24) return 1'b1;
    if (l < 26) return 1'b0;
    return 1'b1;
  endfunction

  bit          hs;
  bit          vs;
  bit [5:0]    m;
  logic [23:0] F;
  bit          ceSeq [5];

  initial begin
    compared   = 0;
    mismatched = 0;
    rst  = 1'b1;
    F    = 24'hFFFFFF;
    vidA.iCE = 0; vidA.iHS = 0; vidA.iVS = 0;
    vidA.iHBLANK = 0; vidA.iVBLANK = 0; vidA.iRGB = 0;

    // Reset overrides iCE, then oCE tracks iCE one clock late.
    for (int i = 0; i < 3; i++)
      step(1, 1, 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 24'($urandom),
           M_ALL, 0, 0, 0, 24'h0, 24'h0, 0, "reset");
    ceSeq = '{1, 0, 1, 1, 0};
    for (int i = 0; i < 5; i++)
      step(0, ceSeq[i], 0, 0, 1, 0, 24'h0, M_CE,
           0, 0, 0, 0, 0, ceSeq[i], "ce_follow");

    // Active-low HS: 96 low / 704 high, locked after the 2nd rise.
    do_reset("reset2");
    for (int l = 0; l < 3; l++)
      for (int s = 0; s < 800; s++) begin
        hs = (s >= 96);
        m  = (l == 2) ? (M_HS | M_VS | M_DE | M_RGB) : 6'd0;
        step(0, 1, hs, 0, 0, 0, 24'h3C5A96, m,
             ~hs, 0, 1, 24'h3C5A96, 0, 0, "hs_low");
      end

    // Active-high HS passes through.
    do_reset("reset3");
    for (int l = 0; l < 3; l++)
      for (int s = 0; s < 800; s++) begin
        hs = (s < 96);
        step(0, 1, hs, 0, 0, 0, 0, M_HS,
             hs, 0, 0, 0, 0, 0, "hs_high");
      end

    // 400/400 tie keeps polarity at 0.
    do_reset("reset_tie");
    for (int g = 0; g < 5; g++)
      for (int s = 0; s < 400; s++) begin
        hs = g[0];
        m  = (g >= 3) ? M_HS : 6'd0;
        step(0, 1, hs, 0, 0, 0, 0, m,
             hs, 0, 0, 0, 0, 0, "hs_tie");
      end

    // VS toggled mid-line only shows at the next HS leading edge.
    do_reset("reset4");
    for (int l = 0; l < 3; l++)
      for (int s = 0; s < 800; s++) begin
        hs = (s < 96);
        vs = (l == 0) ? (s >= 300) : ((l == 1) ? (s < 300) : 1'b0);
        step(0, 1, hs, vs, 0, 0, 0, M_HS | M_VS,
             hs, (l == 1), 0, 0, 0, 0, "vs_align");
      end

    // Active-low VS over short lines: 2 low / 10 high.
    do_reset("reset_vpol");
    for (int l = 0; l < 28; l++)
      for (int s = 0; s < 8; s++) begin
        vs = vsLine(l);
        step(0, 1, (s < 2), vs, 0, 0, 0, M_VS,
             0, (l <= 14) ? vs : ~vs, 0, 0, 0, 0,
             "vs_pol");
      end

    // Blanking, VBLANK latch on HBLANK rise, and CE gating.
    do_reset("reset5");
    m = M_DE | M_RGB | M_RGBB | M_CE;
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 0, 1, 0, F, m, 0, 0, 0, 0, F, 1, "hblank");
    for (int i = 0; i < 10; i++)
      step(0, 1, 0, 0, 0, 0, F, m, 0, 0, 1, F, F, 1, "active");
    for (int i = 0; i < 10; i++)
      step(0, 1, 0, 0, 0, 1, F, m, 0, 0, 1, F, F, 1, "vbl_mid");
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 0, 1, 1, 24'h123456, m | M_HS,
           0, 0, 1, F, F, 0, "ce_hold");
    step(0, 1, 0, 0, 0, 1, 24'h123456, m | M_HS,
         0, 0, 1, 24'h123456, 24'h123456, 1, "ce_resume");
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 0, 1, 1, F, m, 0, 0, 0, 0, F, 1, "vbl_latch");
    for (int i = 0; i < 6; i++)
      step(0, 1, 0, 0, 0, 1, F, m, 0, 0, 0, 0, F, 1, "vbl_active");
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 0, 0, 0, F, m, 0, 0, 0, 0, F, 1, "vbl_held");
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 0, 1, 0, F, m, 0, 0, 0, 0, F, 1, "vbl_clear");
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 0, 0, 0, F, m, 0, 0, 1, F, F, 1, "active2");

    // HS high counter saturates: 5000 high then 2000 low still votes high.
    do_reset("reset6");
    for (int i = 0; i < 5000; i++)
      step(0, 1, 1, 0, 0, 0, 0, M_HS, 1, 0, 0, 0, 0, 0, "sat_hi");
    for (int i = 0; i < 2000; i++)
      step(0, 1, 0, 0, 0, 0, 0, M_HS, 0, 0, 0, 0, 0, 0, "sat_lo");
    step(0, 1, 1, 0, 0, 0, 0, M_HS, 1, 0, 0, 0, 0, 0, "sat_edge");
    for (int i = 0; i < 10; i++)
      step(0, 1, 1, 0, 0, 0, 0, M_HS, 0, 0, 0, 0, 0, 0, "sat_pol_hi");
    for (int i = 0; i < 10; i++)
      step(0, 1, 0, 0, 0, 0, 0, M_HS, 1, 0, 0, 0, 0, 0, "sat_pol_lo");

    @(negedge clk);
    @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
